// File: rtl/alu_pkg.sv
// Shared types for the ALU operand loader, the ALU and its bench.
// Holds the entry-sequence states, the opcode encoding and the LED stage decode.
package alu_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_ADD = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } opcode_t;

  localparam logic [2:0] STAGE_A    = 3'b001;
  localparam logic [2:0] STAGE_B    = 3'b010;
  localparam logic [2:0] STAGE_OP   = 3'b100;
  localparam logic [2:0] STAGE_DONE = 3'b000;

  // One-hot LED pattern for each entry state.
  function automatic logic [2:0] stage_of(state_t s);
    case (s)
      WAIT_A:  return STAGE_A;
      WAIT_B:  return STAGE_B;
      WAIT_OP: return STAGE_OP;
      default: return STAGE_DONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Switch/button inputs and registered ALU operand outputs of the operand loader.
// The master side drives the user inputs; the slave side is the loader itself.
interface alu_operand_loader_if #(
  parameter int M = 8
);
  logic [M-1:0] data_in;
  logic         load;
  logic         clear;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [1:0]   OpCode;
  logic         valid;
  logic [2:0]   stage;

  modport master (
    output data_in, load, clear,
    input  A, B, OpCode, valid, stage
  );

  modport slave (
    input  data_in, load, clear,
    output A, B, OpCode, valid, stage
  );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a clk-synchronous level; emits a one-cycle pulse.
// History resets to 1 so a level already high at reset release is not taken as an edge.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_q <= 1'b1;
    else          level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequences A, B and OpCode entry from switches on successive load presses,
// then holds the complete operand set with valid high until the next press.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int M = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_operand_loader_if.slave  bus
);

  state_t       state_q, state_d;
  logic [M-1:0] a_q, b_q;
  opcode_t      op_q;
  logic         valid_q;
  logic         accept;
  logic         cap_a, cap_b, cap_op;

  // History keeps tracking load even while clear overrides the FSM.
  edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (bus.load),
    .pulse   (accept)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_A;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cap_a   = 1'b0;
    cap_b   = 1'b0;
    cap_op  = 1'b0;
    if (bus.clear) begin
      state_d = WAIT_A;
    end else if (accept) begin
      case (state_q)
        WAIT_A:  begin cap_a  = 1'b1; state_d = WAIT_B;  end
        WAIT_B:  begin cap_b  = 1'b1; state_d = WAIT_OP; end
        WAIT_OP: begin cap_op = 1'b1; state_d = SHOW;    end
        default: state_d = WAIT_A;
      endcase
    end
  end

  // NOTE: operand registers are reset explicitly; partial entries must not survive a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_SUB;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_d == SHOW);
      if (bus.clear) begin
        a_q  <= '0;
        b_q  <= '0;
        op_q <= OP_SUB;
      end else begin
        if (cap_a)  a_q  <= bus.data_in;
        if (cap_b)  b_q  <= bus.data_in;
        if (cap_op) op_q <= opcode_t'(bus.data_in[1:0]);
      end
    end
  end

  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.OpCode = op_q;
  assign bus.valid  = valid_q;
  assign bus.stage  = stage_of(state_q);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader (M=8): directed scenarios plus
// random button/switch activity compared every cycle against a press-counting model.
module tb_alu_operand_loader;

  localparam int M = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   cmp_en      = 1'b0;

  alu_operand_loader_if #(.M(M)) bus ();

  alu_operand_loader #(.M(M)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: count accepted presses modulo 4 and remember what each one captured.
  int         m_phase = 0;
  logic [7:0] m_a     = '0;
  logic [7:0] m_b     = '0;
  logic [1:0] m_op    = '0;
  logic       m_prev  = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_op    <= '0;
      m_prev  <= 1'b1;
    end else begin
      m_prev <= bus.load;
      if (bus.clear) begin
        m_phase <= 0;
        m_a     <= '0;
        m_b     <= '0;
        m_op    <= '0;
      end else if (bus.load && !m_prev) begin
        if (m_phase == 0) m_a <= bus.data_in;
        if (m_phase == 1) m_b <= bus.data_in;
        if (m_phase == 2) m_op <= bus.data_in[1:0];
        m_phase <= (m_phase + 1) % 4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_A",      32'(bus.A),      32'(m_a));
      check("cyc_B",      32'(bus.B),      32'(m_b));
      check("cyc_OpCode", 32'(bus.OpCode), 32'(m_op));
      check("cyc_valid",  32'(bus.valid),  32'(m_phase == 3));
      check("cyc_stage",  32'(bus.stage),  (m_phase == 3) ? 32'd0 : (32'd1 << m_phase));
    end
  end

  task automatic press(input logic [7:0] d);
    @(negedge clk);
    bus.data_in = d;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.data_in = '0;
    bus.load    = 1'b0;
    bus.clear   = 1'b0;
    #2;
    check("rst_stage", 32'(bus.stage), 32'h1);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_A",     32'(bus.A),     32'h0);
    check("rst_OpCode",32'(bus.OpCode),32'h0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full entry sequence
    press(8'h35);
    check("seq_stage_b", 32'(bus.stage), 32'h2);
    press(8'h0F);
    press(8'h01);
    check("seq_A",      32'(bus.A),      32'h35);
    check("seq_B",      32'(bus.B),      32'h0F);
    check("seq_OpCode", 32'(bus.OpCode), 32'h1);
    check("seq_valid",  32'(bus.valid),  32'h1);
    check("seq_stage",  32'(bus.stage),  32'h0);
    repeat (3) @(negedge clk);
    check("show_hold_valid", 32'(bus.valid), 32'h1);

    // Press in SHOW restarts without capturing
    press(8'hFF);
    check("restart_valid", 32'(bus.valid), 32'h0);
    check("restart_stage", 32'(bus.stage), 32'h1);
    check("restart_A",     32'(bus.A),     32'h35);

    // Held load counts once
    @(negedge clk);
    bus.data_in = 8'hAA;
    bus.load    = 1'b1;
    repeat (10) @(negedge clk);
    bus.data_in = 8'h55;
    repeat (3) @(negedge clk);
    check("held_A",     32'(bus.A),     32'hAA);
    check("held_stage", 32'(bus.stage), 32'h2);
    bus.load = 1'b0;

    // Clear beats a simultaneous press in WAIT_OP
    press(8'h22);
    check("pre_clear_stage", 32'(bus.stage), 32'h4);
    @(negedge clk);
    bus.clear   = 1'b1;
    bus.load    = 1'b1;
    bus.data_in = 8'h03;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    check("clr_stage",  32'(bus.stage),  32'h1);
    check("clr_A",      32'(bus.A),      32'h0);
    check("clr_B",      32'(bus.B),      32'h0);
    check("clr_OpCode", 32'(bus.OpCode), 32'h0);
    check("clr_valid",  32'(bus.valid),  32'h0);

    // Load held high across reset release is not accepted
    @(negedge clk);
    bus.data_in = 8'h77;
    bus.load    = 1'b1;
    reset_n     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstheld_A",     32'(bus.A),     32'h0);
    check("rstheld_stage", 32'(bus.stage), 32'h1);
    bus.load = 1'b0;
    press(8'h44);
    check("rstheld_cap_A", 32'(bus.A), 32'h44);

    // Asynchronous reset between edges in WAIT_B
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    press(8'h12);
    check("async_pre_A", 32'(bus.A), 32'h12);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_A",     32'(bus.A),     32'h0);
    check("async_stage", 32'(bus.stage), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // Random button and switch activity
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.data_in = 8'($urandom);
      bus.load    = 1'($urandom_range(0, 1));
      bus.clear   = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    bus.load  = 1'b0;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter M, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  M  operand or opcode value from user switches, sampled on an accepted load.
REQ-005 load  input  1  debounced, clk-synchronous button level; the block detects its rising edge internally.
REQ-006 clear  input  1  synchronous restart of the entry sequence.
REQ-007 A  output  M  registered first operand to the ALU.
REQ-008 B  output  M  registered second operand to the ALU.
REQ-009 OpCode  output  2  registered ALU opcode: 00 SUB, 01 ADD, 10 OR, 11 AND.
REQ-010 valid  output  1  high when A, B and OpCode form a complete, stable operand set.
REQ-011 stage  output  3  one-hot entry indicator for LEDs: 001 awaiting A, 010 awaiting B, 100 awaiting OpCode, 000 complete.

Function
REQ-012 An accepted load SHALL be a cycle with load=1 while load was 0 in the previous cycle; a held level SHALL count once.
REQ-013 The FSM SHALL have four states: WAIT_A, WAIT_B, WAIT_OP, SHOW.
REQ-014 WAIT_A + accepted load: A <= data_in, next WAIT_B; WAIT_B + accepted load: B <= data_in, next WAIT_OP.
REQ-015 WAIT_OP + accepted load: OpCode <= data_in[1:0] (upper bits ignored), next SHOW.
REQ-016 SHOW + accepted load: valid falls, A/B/OpCode retained, next WAIT_A (new entry starts; the data_in of this load is not captured).
REQ-017 Latency: register and state update visible on the cycle after the accepted load cycle; valid rises the same cycle OpCode updates.
REQ-018 valid SHALL be 1 exactly in SHOW; stage SHALL decode combinationally from state.
REQ-019 A, B, OpCode SHALL change only on their own capture or on clear/reset; in SHOW they are constant.
REQ-020 clear=1 SHALL force next state WAIT_A and zero A, B, OpCode; valid is 0 the following cycle.
REQ-021 clear and an accepted load in the same cycle: clear wins, load ignored, edge detector history still updated.
REQ-022 Without accepted loads the FSM SHALL hold state indefinitely; no timeouts.

Reset
REQ-023 reset_n=0 SHALL immediately force WAIT_A, A=0, B=0, OpCode=00, valid=0, stage=001.
REQ-024 The load-history register SHALL reset to 1, so a load held high through reset release is not accepted until released and pressed again.
REQ-025 Reset asserted mid-sequence SHALL discard partial entries; no state survives.

Structure
REQ-026 Package alu_pkg SHALL hold the state enum (WAIT_A, WAIT_B, WAIT_OP, SHOW) and the opcode enum (OP_SUB=00, OP_ADD=01, OP_OR=10, OP_AND=11), shared with the ALU and its bench.
REQ-027 One sub-module, edge_detect (clk, reset_n, level in, one-cycle pulse out, history reset value 1), SHALL implement REQ-012/REQ-024.
REQ-028 Outputs A, B, OpCode, valid SHALL be flop-driven, with no combinational path from data_in to them.

Verification (M=8)
REQ-029 Reset release with load=0; pulses capturing data_in=0x35, 0x0F, 0x01 -> A=0x35, B=0x0F, OpCode=01, valid=1, stage=000, one cycle after third accepted load.
REQ-030 load held high 10 cycles in WAIT_A with data_in=0xAA, then data_in changed to 0x55 while still high -> A=0xAA, stage=010, no further capture.
REQ-031 From SHOW (A=0x35), pulse load with data_in=0xFF -> valid=0, stage=001, A still 0x35.
REQ-032 In WAIT_OP, assert clear and load same cycle -> next cycle stage=001, A=B=0, OpCode=00, valid=0.
REQ-033 load held high across reset_n deassertion -> no capture until load goes 0 then 1; first capture sets A.
REQ-034 reset_n pulsed low asynchronously (between clk edges) in WAIT_B with A=0x12 -> outputs A=0, stage=001 immediately, before next clk edge.
